// File: rtl/mem_access_pkg.sv
// Shared encodings and FSM state type for the load/store sequencer.
// Optional feature macro used by this slice: MEM_ACCESS_ALIGN_CHECK_EN.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_INVALID  = 2'b01;
  localparam logic [1:0] FLT_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    RMW_RD,
    RMW_CAP,
    WR,
    RESP
  } state_t;

  // Encoding 11 is an alias for a full word access.
  function automatic logic [1:0] normSize(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane extract with sign/zero extension for loads, and lane merge
// into a read word for sub-word stores. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  logic [4:0]  w_byteShift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byteShift = {i_off, 3'b000};

  always_comb begin
    w_byte   = i_rdata[w_byteShift +: 8];
    w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load   = i_rdata;
    o_merged = i_wdata;
    case (normSize(i_size))
      SZ_BYTE: begin
        o_load   = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
        o_merged = i_rdata;
        o_merged[w_byteShift +: 8] = i_wdata[7:0];
      end
      // Only off[1] picks the half; off[0] is either faulted earlier or ignored.
      SZ_HALF: begin
        o_load   = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
        o_merged = i_rdata;
        if (i_off[1]) begin
          o_merged[31:16] = i_wdata[15:0];
        end else begin
          o_merged[15:0] = i_wdata[15:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and the single-port data RAM.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [1:0]        req_byte_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              dec_enable,
  input  logic [ADDR_W-1:0] dec_phys_addr,
  input  logic              dec_invalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_fault
);

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [1:0]        r_fault;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_result;
  logic [ADDR_W-1:0] r_physAddr;

  logic              w_accept;
  logic              w_misalign;
  logic [1:0]        w_fault;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign req_ready  = (r_state == IDLE);
  assign w_accept   = req_valid & req_ready;
  assign dec_enable = w_accept;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_misalign = ((normSize(req_size) == SZ_HALF) && req_byte_off[0]) ||
                      ((normSize(req_size) == SZ_WORD) && (req_byte_off != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // An invalid address outranks a misaligned one.
  always_comb begin
    w_fault = FLT_NONE;
    if (dec_invalid) begin
      w_fault = FLT_INVALID;
    end else if (w_misalign) begin
      w_fault = FLT_MISALIGN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fault != FLT_NONE) begin
            w_nextState = RESP;
          end else if (!req_write) begin
            w_nextState = RD;
          end else if (normSize(req_size) == SZ_WORD) begin
            w_nextState = WR;
          end else begin
            w_nextState = RMW_RD;
          end
        end
      end
      RD:      w_nextState = CAP;
      CAP:     w_nextState = RESP;
      RMW_RD:  w_nextState = RMW_CAP;
      RMW_CAP: w_nextState = WR;
      WR:      w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // r_wdata is reused to hold the merged word between RMW_CAP and WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_off      <= 2'b00;
      r_fault    <= FLT_NONE;
      r_wdata    <= '0;
      r_result   <= '0;
      r_physAddr <= '0;
    end else begin
      if (w_accept) begin
        r_size     <= req_size;
        r_signed   <= req_signed;
        r_off      <= req_byte_off;
        r_fault    <= w_fault;
        r_wdata    <= req_wdata;
        r_result   <= '0;
        r_physAddr <= dec_phys_addr;
      end
      if (r_state == CAP) begin
        r_result <= w_load;
      end
      if (r_state == RMW_CAP) begin
        r_wdata <= w_merged;
      end
    end
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_off    (r_off),
    .i_rdata  (mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign mem_addr   = (r_state == IDLE) ? '0 : r_physAddr;
  assign mem_wen    = (r_state == WR);
  assign mem_wdata  = mem_wen ? r_wdata : '0;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_result : '0;
  assign resp_fault = resp_valid ? r_fault : FLT_NONE;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a synchronous-read RAM model.
// Expectations follow MEM_ACCESS_ALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [10:0] pa;
    logic        inv;
    logic [31:0] expRdata;
    logic [1:0]  expFault;
    int          expRespLat;
    int          expWenLat;
    logic [31:0] expWenData;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size, req_byte_off;
  logic [31:0] req_wdata;
  logic        dec_enable, dec_invalid;
  logic [10:0] dec_phys_addr, mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata, mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;

  logic [31:0] ram [0:2047];
  logic        preEn;
  logic [10:0] preAddr;
  logic [31:0] preData;

  int nCompared   = 0;
  int nMismatched = 0;
  int wenEvents   = 0;
  int respEvents  = 0;
  vec_t sbq[$];

  mem_access_unit #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_byte_off  (req_byte_off),
    .req_wdata     (req_wdata),
    .dec_enable    (dec_enable),
    .dec_phys_addr (dec_phys_addr),
    .dec_invalid   (dec_invalid),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, full-word write, bench backdoor preload.
  always @(posedge clk) begin
    if (preEn) begin
      ram[preAddr] <= preData;
    end else if (mem_wen) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_wen === 1'b1) wenEvents++;
    if (resp_valid === 1'b1) respEvents++;
  end

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [1:0] off, input logic [31:0] wd, input logic [10:0] pa,
                              input logic inv, input logic [31:0] expRd, input logic [1:0] expFlt,
                              input int respLat, input int wenLat, input logic [31:0] wenData);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.off = off; v.wd = wd; v.pa = pa; v.inv = inv;
    v.expRdata = expRd; v.expFault = expFlt; v.expRespLat = respLat;
    v.expWenLat = wenLat; v.expWenData = wenData;
    return v;
  endfunction

  task automatic preloadWord(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge clk);
    #1 preEn = 1'b0;
  endtask

  // Drives one request at a negedge and watches up to 20 cycles after acceptance.
  task automatic doReq(input vec_t v, output logic readyAtDrive, output logic decEnAtDrive,
                       output int respLat, output int wenLat, output logic [31:0] wenData,
                       output logic [10:0] wenAddr, output logic [31:0] rdata,
                       output logic [1:0] fault, output bit timedOut);
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_byte_off = v.off; req_wdata = v.wd; dec_phys_addr = v.pa; dec_invalid = v.inv;
    #1;
    readyAtDrive = req_ready;
    decEnAtDrive = dec_enable;
    @(posedge clk);
    #1;
    req_valid = 1'b0; dec_invalid = 1'b0;
    respLat = -1; wenLat = -1; wenData = '0; wenAddr = '0; rdata = '0; fault = '0;
    timedOut = 1'b1;
    for (int lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (mem_wen === 1'b1 && wenLat < 0) begin
        wenLat = lat; wenData = mem_wdata; wenAddr = mem_addr;
      end
      if (resp_valid === 1'b1) begin
        respLat = lat; rdata = resp_rdata; fault = resp_fault; timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_byte_off = 2'b00; req_wdata = '0; dec_phys_addr = '0; dec_invalid = 1'b0;
    preEn = 1'b0; preAddr = '0; preData = '0;
    repeat (3) @(negedge clk);
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
    nCompared++; if (resp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    nCompared++; if (resp_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    nCompared++; if (resp_fault !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_resp_fault: got %b want 00", resp_fault); end
    nCompared++; if (mem_wen !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_wen: got %b want 0", mem_wen); end
    nCompared++; if (mem_addr !== 11'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    nCompared++; if (mem_wdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    nCompared++; if (dec_enable !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dec_enable: got %b want 0", dec_enable); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    vec_t tab[$];
    vec_t e;
    logic rdy, den;
    int rl, wl;
    logic [31:0] wdat, rd;
    logic [10:0] wadr;
    logic [1:0] fl;
    bit to;
    preloadWord(11'd1, 32'h8899AABB);
    preloadWord(11'd5, 32'h127F3456);
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b1, 2'd3, 32'h0, 11'd1, 1'b0, 32'hFFFFFF88, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b0, 2'd3, 32'h0, 11'd1, 1'b0, 32'h00000088, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b1, 2'd0, 32'h0, 11'd1, 1'b0, 32'hFFFFFFBB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b0, 2'd1, 32'h0, 11'd1, 1'b0, 32'h000000AA, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd2, 32'h0, 11'd1, 1'b0, 32'hFFFF8899, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_HALF, 1'b0, 2'd0, 32'h0, 11'd1, 1'b0, 32'h0000AABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd0, 32'h0, 11'd1, 1'b0, 32'h8899AABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, 2'b11,   1'b1, 2'd0, 32'h0, 11'd1, 1'b0, 32'h8899AABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b1, 2'd2, 32'h0, 11'd5, 1'b0, 32'h0000007F, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd0, 32'h0, 11'd5, 1'b0, 32'h00003456, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd2, 32'h0, 11'd5, 1'b0, 32'h0000127F, FLT_NONE, 3, -1, 32'h0));
    for (int i = 0; i < tab.size(); i++) begin
      sbq.push_back(tab[i]);
      doReq(tab[i], rdy, den, rl, wl, wdat, wadr, rd, fl, to);
      e = sbq.pop_front();
      nCompared++;
      if (to) begin
        nMismatched++; $display("[TB] FAIL load[%0d]_timeout: no resp_valid within 20 cycles, want latency %0d", i, e.expRespLat);
      end else begin
        nCompared++; if (rl != e.expRespLat) begin nMismatched++; $display("[TB] FAIL load[%0d]_latency: got %0d want %0d", i, rl, e.expRespLat); end
        nCompared++; if (rd !== e.expRdata) begin nMismatched++; $display("[TB] FAIL load[%0d]_rdata: got %h want %h", i, rd, e.expRdata); end
        nCompared++; if (fl !== e.expFault) begin nMismatched++; $display("[TB] FAIL load[%0d]_fault: got %b want %b", i, fl, e.expFault); end
        nCompared++; if (wl != e.expWenLat) begin nMismatched++; $display("[TB] FAIL load[%0d]_wen: got latency %0d want %0d", i, wl, e.expWenLat); end
      end
    end
  endtask

  task automatic test_word_store();
    vec_t tab[$];
    vec_t e;
    logic rdy, den;
    int rl, wl;
    logic [31:0] wdat, rd;
    logic [10:0] wadr;
    logic [1:0] fl;
    bit to;
    tab.push_back(mk(1'b1, SZ_WORD, 1'b0, 2'd0, 32'hDEADBEEF, 11'd2, 1'b0, 32'h0, FLT_NONE, 2, 1, 32'hDEADBEEF));
    tab.push_back(mk(1'b1, 2'b11,   1'b0, 2'd0, 32'h0BADF00D, 11'd6, 1'b0, 32'h0, FLT_NONE, 2, 1, 32'h0BADF00D));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd0, 32'h0, 11'd2, 1'b0, 32'hDEADBEEF, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd0, 32'h0, 11'd6, 1'b0, 32'h0BADF00D, FLT_NONE, 3, -1, 32'h0));
    for (int i = 0; i < tab.size(); i++) begin
      sbq.push_back(tab[i]);
      doReq(tab[i], rdy, den, rl, wl, wdat, wadr, rd, fl, to);
      e = sbq.pop_front();
      nCompared++;
      if (to) begin
        nMismatched++; $display("[TB] FAIL sw[%0d]_timeout: no resp_valid within 20 cycles, want latency %0d", i, e.expRespLat);
      end else begin
        nCompared++; if (rl != e.expRespLat) begin nMismatched++; $display("[TB] FAIL sw[%0d]_latency: got %0d want %0d", i, rl, e.expRespLat); end
        nCompared++; if (rd !== e.expRdata) begin nMismatched++; $display("[TB] FAIL sw[%0d]_rdata: got %h want %h", i, rd, e.expRdata); end
        nCompared++; if (fl !== e.expFault) begin nMismatched++; $display("[TB] FAIL sw[%0d]_fault: got %b want %b", i, fl, e.expFault); end
        nCompared++; if (wl != e.expWenLat) begin nMismatched++; $display("[TB] FAIL sw[%0d]_wen_latency: got %0d want %0d", i, wl, e.expWenLat); end
        if (e.expWenLat > 0) begin
          nCompared++; if (wdat !== e.expWenData) begin nMismatched++; $display("[TB] FAIL sw[%0d]_wdata: got %h want %h", i, wdat, e.expWenData); end
          nCompared++; if (wadr !== e.pa) begin nMismatched++; $display("[TB] FAIL sw[%0d]_waddr: got %h want %h", i, wadr, e.pa); end
        end
      end
    end
    nCompared++; if (ram[2] !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL sw_ram2: got %h want deadbeef", ram[2]); end
  endtask

  task automatic test_subword_store();
    vec_t tab[$];
    vec_t e;
    logic rdy, den;
    int rl, wl;
    logic [31:0] wdat, rd;
    logic [10:0] wadr;
    logic [1:0] fl;
    bit to;
    preloadWord(11'd1, 32'h8899AABB);
    preloadWord(11'd3, 32'h11111111);
    tab.push_back(mk(1'b1, SZ_BYTE, 1'b0, 2'd1, 32'hFFFFFF5A, 11'd1, 1'b0, 32'h0, FLT_NONE, 4, 3, 32'h88995ABB));
    tab.push_back(mk(1'b1, SZ_HALF, 1'b0, 2'd2, 32'hCAFE1234, 11'd3, 1'b0, 32'h0, FLT_NONE, 4, 3, 32'h12341111));
    tab.push_back(mk(1'b1, SZ_BYTE, 1'b0, 2'd3, 32'h00000077, 11'd3, 1'b0, 32'h0, FLT_NONE, 4, 3, 32'h77341111));
    tab.push_back(mk(1'b1, SZ_HALF, 1'b0, 2'd0, 32'h0000BEEF, 11'd3, 1'b0, 32'h0, FLT_NONE, 4, 3, 32'h7734BEEF));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd0, 32'h0, 11'd1, 1'b0, 32'h88995ABB, FLT_NONE, 3, -1, 32'h0));
    for (int i = 0; i < tab.size(); i++) begin
      sbq.push_back(tab[i]);
      doReq(tab[i], rdy, den, rl, wl, wdat, wadr, rd, fl, to);
      e = sbq.pop_front();
      nCompared++;
      if (to) begin
        nMismatched++; $display("[TB] FAIL rmw[%0d]_timeout: no resp_valid within 20 cycles, want latency %0d", i, e.expRespLat);
      end else begin
        nCompared++; if (rl != e.expRespLat) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_latency: got %0d want %0d", i, rl, e.expRespLat); end
        nCompared++; if (rd !== e.expRdata) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_rdata: got %h want %h", i, rd, e.expRdata); end
        nCompared++; if (fl !== e.expFault) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_fault: got %b want %b", i, fl, e.expFault); end
        nCompared++; if (wl != e.expWenLat) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_wen_latency: got %0d want %0d", i, wl, e.expWenLat); end
        if (e.expWenLat > 0) begin
          nCompared++; if (wdat !== e.expWenData) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_wdata: got %h want %h", i, wdat, e.expWenData); end
          nCompared++; if (wadr !== e.pa) begin nMismatched++; $display("[TB] FAIL rmw[%0d]_waddr: got %h want %h", i, wadr, e.pa); end
        end
      end
    end
  endtask

  task automatic test_fault();
    vec_t tab[$];
    vec_t e;
    logic rdy, den;
    int rl, wl;
    logic [31:0] wdat, rd;
    logic [10:0] wadr;
    logic [1:0] fl;
    bit to;
    tab.push_back(mk(1'b1, SZ_WORD, 1'b0, 2'd0, 32'h01234567, 11'd2, 1'b1, 32'h0, FLT_INVALID, 1, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd1, 32'h0, 11'd1, 1'b1, 32'h0, FLT_INVALID, 1, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b1, 2'd0, 32'h0, 11'd1, 1'b1, 32'h0, FLT_INVALID, 1, -1, 32'h0));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd1, 32'h0, 11'd1, 1'b0, 32'h0, FLT_MISALIGN, 1, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd2, 32'h0, 11'd1, 1'b0, 32'h0, FLT_MISALIGN, 1, -1, 32'h0));
    tab.push_back(mk(1'b1, SZ_HALF, 1'b0, 2'd1, 32'h00004321, 11'd3, 1'b0, 32'h0, FLT_MISALIGN, 1, -1, 32'h0));
`else
    tab.push_back(mk(1'b0, SZ_HALF, 1'b1, 2'd1, 32'h0, 11'd1, 1'b0, 32'h00005ABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd2, 32'h0, 11'd1, 1'b0, 32'h88995ABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b1, SZ_HALF, 1'b0, 2'd1, 32'h00004321, 11'd3, 1'b0, 32'h0, FLT_NONE, 4, 3, 32'h77344321));
`endif
    tab.push_back(mk(1'b1, SZ_BYTE, 1'b0, 2'd0, 32'h000000FF, 11'd3, 1'b1, 32'h0, FLT_INVALID, 1, -1, 32'h0));
    for (int i = 0; i < tab.size(); i++) begin
      sbq.push_back(tab[i]);
      doReq(tab[i], rdy, den, rl, wl, wdat, wadr, rd, fl, to);
      e = sbq.pop_front();
      nCompared++;
      if (to) begin
        nMismatched++; $display("[TB] FAIL fault[%0d]_timeout: no resp_valid within 20 cycles, want latency %0d", i, e.expRespLat);
      end else begin
        nCompared++; if (rl != e.expRespLat) begin nMismatched++; $display("[TB] FAIL fault[%0d]_latency: got %0d want %0d", i, rl, e.expRespLat); end
        nCompared++; if (rd !== e.expRdata) begin nMismatched++; $display("[TB] FAIL fault[%0d]_rdata: got %h want %h", i, rd, e.expRdata); end
        nCompared++; if (fl !== e.expFault) begin nMismatched++; $display("[TB] FAIL fault[%0d]_code: got %b want %b", i, fl, e.expFault); end
        nCompared++; if (wl != e.expWenLat) begin nMismatched++; $display("[TB] FAIL fault[%0d]_wen_latency: got %0d want %0d", i, wl, e.expWenLat); end
        if (e.expWenLat > 0) begin
          nCompared++; if (wdat !== e.expWenData) begin nMismatched++; $display("[TB] FAIL fault[%0d]_wdata: got %h want %h", i, wdat, e.expWenData); end
        end
      end
    end
    nCompared++; if (ram[2] !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL fault_ram2_untouched: got %h want deadbeef", ram[2]); end
  endtask

  task automatic test_back_to_back();
    vec_t tab[$];
    vec_t e;
    logic rdy, den;
    int rl, wl;
    logic [31:0] wdat, rd;
    logic [10:0] wadr;
    logic [1:0] fl;
    bit to;
    tab.push_back(mk(1'b0, SZ_WORD, 1'b0, 2'd0, 32'h0, 11'd1, 1'b0, 32'h88995ABB, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b0, 2'd3, 32'h0, 11'd3, 1'b0, 32'h00000077, FLT_NONE, 3, -1, 32'h0));
    tab.push_back(mk(1'b0, SZ_BYTE, 1'b1, 2'd1, 32'h0, 11'd1, 1'b0, 32'h0000005A, FLT_NONE, 3, -1, 32'h0));
    for (int i = 0; i < tab.size(); i++) begin
      sbq.push_back(tab[i]);
      doReq(tab[i], rdy, den, rl, wl, wdat, wadr, rd, fl, to);
      e = sbq.pop_front();
      nCompared++; if (rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b[%0d]_ready: got %b want 1", i, rdy); end
      nCompared++; if (den !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b[%0d]_dec_enable: got %b want 1", i, den); end
      nCompared++;
      if (to) begin
        nMismatched++; $display("[TB] FAIL b2b[%0d]_timeout: no resp_valid within 20 cycles, want latency %0d", i, e.expRespLat);
      end else begin
        nCompared++; if (rl != e.expRespLat) begin nMismatched++; $display("[TB] FAIL b2b[%0d]_latency: got %0d want %0d", i, rl, e.expRespLat); end
        nCompared++; if (rd !== e.expRdata) begin nMismatched++; $display("[TB] FAIL b2b[%0d]_rdata: got %h want %h", i, rd, e.expRdata); end
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int wenBefore, respBefore;
    preloadWord(11'd4, 32'h11223344);
    wenBefore  = wenEvents;
    respBefore = respEvents;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_byte_off = 2'd0; req_wdata = 32'h000000EE; dec_phys_addr = 11'd4; dec_invalid = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstrmw_busy: got ready %b want 0", req_ready); end
    nCompared++; if (mem_addr !== 11'd4) begin nMismatched++; $display("[TB] FAIL rstrmw_addr: got %h want 004", mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    nCompared++; if (mem_wen !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstrmw_wen_now: got %b want 0", mem_wen); end
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstrmw_ready_async: got %b want 1", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    nCompared++; if (wenEvents != wenBefore) begin nMismatched++; $display("[TB] FAIL rstrmw_no_write: got %0d strobes want 0", wenEvents - wenBefore); end
    nCompared++; if (respEvents != respBefore) begin nMismatched++; $display("[TB] FAIL rstrmw_no_resp: got %0d responses want 0", respEvents - respBefore); end
    nCompared++; if (ram[4] !== 32'h11223344) begin nMismatched++; $display("[TB] FAIL rstrmw_word: got %h want 11223344", ram[4]); end
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstrmw_ready_after: got %b want 1", req_ready); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_load();
    test_word_store();
    test_subword_store();
    test_fault();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
